// File: rtl/multicycle_mem.sv
// Fixed-latency, fully pipelined single-port 16-bit word memory.
// Requests are delayed LATENCY-1 stages, then executed strictly in issue order.
module multicycle_mem #(
   parameter int DEPTH_LOG2 = 13,
   parameter int LATENCY    = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        wr,
   input  logic [15:0] addr,
   input  logic [15:0] data_in,
   output logic [15:0] data_out,
   output logic        data_valid,
   output logic        busy
);

   localparam int WORDS  = 1 << DEPTH_LOG2;
   // Keep at least one stage so the declarations stay legal when LATENCY is 1.
   localparam int STAGES = (LATENCY > 1) ? LATENCY - 1 : 1;

   logic [15:0]           mem_r [0:WORDS-1];
   logic [STAGES-1:0]     vld_r;
   logic [STAGES-1:0]     wr_r;
   logic [DEPTH_LOG2-1:0] idx_r [0:STAGES-1];
   logic [15:0]           dat_r [0:STAGES-1];

   logic [DEPTH_LOG2-1:0] req_idx_s;
   logic                  exec_vld_s;
   logic                  exec_wr_s;
   logic [DEPTH_LOG2-1:0] exec_idx_s;
   logic [15:0]           exec_dat_s;

   assign req_idx_s = addr[DEPTH_LOG2:1];

   // Select the request that executes at the coming edge.
   always_comb begin
      exec_vld_s = 1'b0;
      exec_wr_s  = 1'b0;
      exec_idx_s = {DEPTH_LOG2{1'b0}};
      exec_dat_s = 16'h0000;
      if (LATENCY == 1) begin
         exec_vld_s = enable;
         exec_wr_s  = wr;
         exec_idx_s = req_idx_s;
         exec_dat_s = data_in;
      end else begin
         exec_vld_s = vld_r[STAGES-1];
         exec_wr_s  = wr_r[STAGES-1];
         exec_idx_s = idx_r[STAGES-1];
         exec_dat_s = dat_r[STAGES-1];
      end
   end

   // Request pipeline; reset drops everything in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_r <= {STAGES{1'b0}};
         wr_r  <= {STAGES{1'b0}};
         for (int i = 0; i < STAGES; i++) begin
            idx_r[i] <= {DEPTH_LOG2{1'b0}};
            dat_r[i] <= 16'h0000;
         end
      end else begin
         vld_r[0] <= enable;
         wr_r[0]  <= wr;
         idx_r[0] <= req_idx_s;
         dat_r[0] <= data_in;
         for (int i = 1; i < STAGES; i++) begin
            vld_r[i] <= vld_r[i-1];
            wr_r[i]  <= wr_r[i-1];
            idx_r[i] <= idx_r[i-1];
            dat_r[i] <= dat_r[i-1];
         end
      end
   end

   // Array write; contents survive reset but a write executing at a reset edge is dropped.
   always_ff @(posedge clk) begin
      if (rst_n && exec_vld_s && exec_wr_s) begin
         mem_r[exec_idx_s] <= exec_dat_s;
      end
   end

   // Read response register; data_out is held at zero whenever no strobe is issued.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_out   <= 16'h0000;
         data_valid <= 1'b0;
      end else if (exec_vld_s && !exec_wr_s) begin
         data_out   <= mem_r[exec_idx_s];
         data_valid <= 1'b1;
      end else begin
         data_out   <= 16'h0000;
         data_valid <= 1'b0;
      end
   end

   assign busy = (LATENCY > 1) ? (|vld_r) : 1'b0;

endmodule

// File: tb/tb_multicycle_mem.sv
// Scoreboard bench for multicycle_mem: directed scenarios plus randomized traffic,
// checked against a timestamped execution model.
module tb_multicycle_mem;

   localparam int DLOG = 13;
   localparam int LAT  = 4;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        wr;
   logic [15:0] addr;
   logic [15:0] data_in;
   logic [15:0] data_out;
   logic        data_valid;
   logic        busy;

   multicycle_mem #(.DEPTH_LOG2(DLOG), .LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .addr(addr),
      .data_in(data_in), .data_out(data_out), .data_valid(data_valid), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { bit is_wr; int idx; logic [15:0] data; int exec_cyc; } req_t;
   typedef struct { logic [15:0] data; bit chk; int cyc; } rsp_t;

   req_t        pending[$];
   rsp_t        sb[$];
   logic [15:0] model_mem[int];
   int          cyc      = 0;
   bit          mon_en   = 1'b0;
   bit          exp_busy = 1'b0;
   int          ncmp     = 0;
   int          nerr     = 0;

   function automatic int word_of(input logic [15:0] a);
      return (int'(a) >> 1) & ((1 << DLOG) - 1);
   endfunction

   // Execute one request against the model memory.
   function automatic void model_exec(input req_t r, input int edge_cyc);
      rsp_t s;
      if (r.is_wr) begin
         model_mem[r.idx] = r.data;
      end else begin
         s.chk  = model_mem.exists(r.idx);
         s.data = s.chk ? model_mem[r.idx] : 16'h0000;
         s.cyc  = edge_cyc + 1;
         sb.push_back(s);
      end
   endfunction

   // Drive one cycle; the model advances at the edge that ends it.
   task automatic step(input bit rst, input bit en, input bit w,
                       input logic [15:0] a, input logic [15:0] d);
      req_t r;
      rst_n = ~rst; enable = en; wr = w; addr = a; data_in = d;
      @(posedge clk);
      if (rst) begin
         pending.delete();
      end else begin
         if (pending.size() > 0 && pending[0].exec_cyc == cyc) begin
            r = pending.pop_front();
            model_exec(r, cyc);
         end
         if (en) begin
            r.is_wr = w; r.idx = word_of(a); r.data = d; r.exec_cyc = cyc + LAT - 1;
            if (LAT == 1) model_exec(r, cyc);
            else pending.push_back(r);
         end
      end
      exp_busy = (pending.size() > 0);
      cyc++;
      mon_en = 1'b1;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
   endtask

   // Monitor: compares DUT outputs against the scoreboard mid-cycle.
   always @(negedge clk) begin
      if (mon_en) begin
         ncmp++;
         if (busy !== exp_busy) begin
            nerr++;
            $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
         end
         if (data_valid === 1'b1) begin
            ncmp++;
            if (sb.size() == 0) begin
               nerr++;
               $display("FAIL unexpected_valid cyc=%0d got=%h exp=no_response", cyc, data_out);
            end else if (sb[0].cyc != cyc) begin
               nerr++;
               $display("FAIL rsp_timing cyc=%0d got=%0d exp=%0d", cyc, cyc, sb[0].cyc);
               void'(sb.pop_front());
            end else begin
               if (sb[0].chk && data_out !== sb[0].data) begin
                  nerr++;
                  $display("FAIL rsp_data cyc=%0d got=%h exp=%h", cyc, data_out, sb[0].data);
               end
               void'(sb.pop_front());
            end
         end else begin
            ncmp++;
            if (data_valid !== 1'b0 || data_out !== 16'h0000) begin
               nerr++;
               $display("FAIL idle_out cyc=%0d got=%b/%h exp=0/0000", cyc, data_valid, data_out);
            end
            if (sb.size() > 0 && sb[0].cyc <= cyc) begin
               nerr++;
               $display("FAIL missing_rsp cyc=%0d got=none exp=%h", cyc, sb[0].data);
               void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      logic [15:0] a;
      rst_n = 1'b0; enable = 1'b0; wr = 1'b0; addr = 16'h0000; data_in = 16'h0000;
      // Reset with a read request presented: must be ignored.
      step(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000);
      step(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000);
      idle(1);
      // Write then read back-to-back.
      step(1'b0, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
      step(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
      idle(LAT + 2);
      // Ordering: read old, write, read new.
      step(1'b0, 1'b1, 1'b1, 16'h0020, 16'h1111);
      idle(LAT);
      step(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000);
      step(1'b0, 1'b1, 1'b1, 16'h0020, 16'h2222);
      step(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000);
      idle(LAT + 2);
      // Streaming prefill and 8 back-to-back reads.
      for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b1, 16'(i * 2), 16'hA000 + 16'(i));
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 16'(i * 2), 16'h0000);
      idle(LAT + 2);
      // Reset mid-flight drops the in-flight write.
      step(1'b0, 1'b1, 1'b1, 16'h0030, 16'h0000);
      idle(LAT);
      step(1'b0, 1'b1, 1'b1, 16'h0030, 16'h5555);
      idle(1);
      step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      step(1'b0, 1'b1, 1'b0, 16'h0030, 16'h0000);
      idle(LAT + 2);
      // Aliasing through addr[0] and bits above the word index.
      step(1'b0, 1'b1, 1'b1, 16'h0041, 16'h1234);
      step(1'b0, 1'b1, 1'b0, 16'h4040, 16'h0000);
      idle(LAT + 2);
      // Randomized traffic over a small, aliased address window.
      for (int i = 0; i < 64; i++) step(1'b0, 1'b1, 1'b1, 16'(i * 2), 16'($urandom));
      for (int i = 0; i < 3000; i++) begin
         a = 16'($urandom_range(0, 63) * 2);
         a[0] = 1'($urandom);
         a[15:14] = 2'($urandom);
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
              1'($urandom), a, 16'($urandom));
      end
      idle(LAT + 3);
      ncmp++;
      if (sb.size() != 0) begin
         nerr++;
         $display("FAIL drain got=%0d exp=0 outstanding responses", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule

// File: doc/multicycle_mem.md
# multicycle_mem

Fixed-latency, fully pipelined, single-port 16-bit word memory that serves as the responder end of the CPU's instruction/data memory interface. It accepts one read or write request per cycle from the core and returns read data with a one-cycle `data_valid` strobe exactly `LATENCY` cycles later. It replaces the zero-latency memory so the core and its future cache/stall logic can be exercised against realistic memory timing.

## Interface
- `DEPTH_LOG2`, 13: number of word-address bits; array holds 2^DEPTH_LOG2 16-bit words.
- `LATENCY`, 4: request-to-response cycles; legal range 1..8.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `enable` input 1: request valid this cycle.
- `wr` input 1: 1 = write, 0 = read; qualified by `enable`.
- `addr` input 16: byte address; the word index is `addr[DEPTH_LOG2:1]`; `addr[0]` and bits above `DEPTH_LOG2` are ignored.
- `data_in` input 16: write data; qualified by `enable & wr`.
- `data_out` output 16: read data; nonzero only while `data_valid` is high.
- `data_valid` output 1: one-cycle strobe, high for each read response.
- `busy` output 1: high while any accepted request has not yet executed.

## Operation
- No backpressure. A request is accepted in every cycle with `enable`=1 and `rst_n`=1.
- Requests travel through `LATENCY-1` request-pipeline stages. Each stage holds `valid`, `wr`, word index and data.
- Execute step: the request leaving the last stage (or the incoming request when `LATENCY`=1) is executed at a clock edge.
  - Write: updates the array at that edge. No response is produced.
  - Read: loads the array word into the `data_out` register and sets `data_valid`.
- Requests execute strictly in issue order, one per edge.
  - A read issued any number of cycles after a write to the same word returns the new data, including back-to-back.
  - A read issued before a write returns the old data.
- `data_out` is forced to 0 in any cycle where `data_valid`=0.
- `busy` = OR of all stage valid bits.
- Array contents are not cleared by reset. The bench must write a location before reading it.
- Aliasing: byte addresses differing only in `addr[0]`, or in bits above `DEPTH_LOG2`, map to the same word.
- Reset (`rst_n`=0 at an edge):
  - Clears all stage valid bits, `data_valid` and `data_out`.
  - In-flight requests are dropped; in-flight writes are never committed.
  - A request presented in the same cycle as reset is ignored.
- Reset values: `data_out`=0, `data_valid`=0, `busy`=0.

## Timing
- A request presented in cycle n is captured at the edge ending cycle n.
- It executes at the edge ending cycle n+LATENCY-1.
- For a read, `data_out`/`data_valid` are visible throughout cycle n+LATENCY.
- With `LATENCY`=1, a read in cycle n responds in cycle n+1, and a write is visible to a read issued in cycle n+1.
- Throughput: one request per cycle indefinitely. Consecutive reads produce `data_valid` on consecutive cycles.
- `busy`:
  - Rises in the cycle after the first accepted request.
  - Falls in the cycle after the last in-flight request executes.
  - For a single request with `LATENCY`=4, `busy` is high in cycles n+1..n+3.
- No combinational path from any input to any output.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `enable`=1 and `wr`=0 -> `data_valid`=0, `data_out`=0 and `busy`=0 throughout and in the first cycle after release.
- Write then read: write 0xBEEF to 0x0010 in cycle 0, read 0x0010 in cycle 1 (`LATENCY`=4) -> `data_valid`=1 and `data_out`=0xBEEF in cycle 5 only; `data_valid`=0 in cycles 0-4 and 6.
- Ordering: read 0x0020 (old value 0x1111), then write 0x2222 to 0x0020, then read 0x0020 on consecutive cycles 0-2 -> responses 0x1111 in cycle 4 and 0x2222 in cycle 6; no strobe in cycle 5.
- Streaming: prefill words 0x0000-0x000E with 0xA000+index, then issue 8 back-to-back reads -> 8 consecutive `data_valid` cycles with data 0xA000..0xA007 in order; `busy` stays continuously high during the burst.
- Reset mid-flight: write 0x5555 to 0x0030 (previously 0x0000) in cycle 0, assert `rst_n`=0 in cycle 2, then read 0x0030 -> returns 0x0000; no `data_valid` during or right after reset.
- Aliasing: write 0x1234 to addr 0x0041, then read addr 0x4040 (`DEPTH_LOG2`=13) -> read returns 0x1234.
